// File: rtl/traffic_conflict_monitor.sv
// Lamp-side safety monitor for a two-approach (A/B) signal head: detects illegal
// lamp states and bad transitions, latches a fault code and requests red flashing.
module traffic_conflict_monitor #(
    parameter int FILTER     = 2,
    parameter int MIN_YELLOW = 3,
    parameter int FLASH_HALF = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       Ga,
    input  logic       Ya,
    input  logic       Ra,
    input  logic       Gb,
    input  logic       Yb,
    input  logic       Rb,
    input  logic       clr_fault,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic       flash_on,
    output logic       ok
);

    localparam logic [3:0] FILT_N = 4'(FILTER);
    localparam logic [3:0] MIN_Y  = 4'(MIN_YELLOW);
    localparam logic [7:0] FH_M1  = 8'(FLASH_HALF - 1);

    localparam logic [2:0] C_CONFLICT = 3'd1;
    localparam logic [2:0] C_MULTI    = 3'd2;
    localparam logic [2:0] C_DARK     = 3'd3;
    localparam logic [2:0] C_SHORT_Y  = 3'd4;
    localparam logic [2:0] C_G2R      = 3'd5;

    typedef enum logic [1:0] {
        S_MONITOR,
        S_PENDING,
        S_FAULT
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] code_q, code_d;
    logic       flash_q, flash_d;
    logic [7:0] fcnt_q, fcnt_d;
    logic [3:0] filt_q, filt_d;
    logic [3:0] ycnt_a_q, ycnt_a_d;
    logic [3:0] ycnt_b_q, ycnt_b_d;
    logic       prev_ga_q, prev_ga_d;
    logic       prev_ya_q, prev_ya_d;
    logic       prev_gb_q, prev_gb_d;
    logic       prev_yb_q, prev_yb_d;

    // Static conditions on the lamps as they are right now
    logic       conflict, multi, dark, static_raw;
    logic [2:0] static_code;

    always_comb begin
        conflict   = (Ga | Ya) & (Gb | Yb);
        multi      = (Ga & Ya) | (Ga & Ra) | (Ya & Ra) |
                     (Gb & Yb) | (Gb & Rb) | (Yb & Rb);
        dark       = ~(Ga | Ya | Ra) | ~(Gb | Yb | Rb);
        static_raw = conflict | multi | dark;
        if (conflict)   static_code = C_CONFLICT;
        else if (multi) static_code = C_MULTI;
        else if (dark)  static_code = C_DARK;
        else            static_code = 3'd0;
    end

    // Transition events against the previous sample; history is zero after reset
    logic       short_y, g2r, event_any;
    logic [2:0] event_code;

    always_comb begin
        short_y    = (prev_ya_q & ~Ya & (ycnt_a_q < MIN_Y)) |
                     (prev_yb_q & ~Yb & (ycnt_b_q < MIN_Y));
        g2r        = (prev_ga_q & Ra) | (prev_gb_q & Rb);
        event_any  = short_y | g2r;
        event_code = short_y ? C_SHORT_Y : C_G2R;
    end

    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        flash_d   = flash_q;
        fcnt_d    = fcnt_q;
        filt_d    = filt_q;
        prev_ga_d = Ga;
        prev_ya_d = Ya;
        prev_gb_d = Gb;
        prev_yb_d = Yb;
        ycnt_a_d  = Ya ? ((ycnt_a_q == MIN_Y) ? ycnt_a_q : ycnt_a_q + 4'd1) : 4'd0;
        ycnt_b_d  = Yb ? ((ycnt_b_q == MIN_Y) ? ycnt_b_q : ycnt_b_q + 4'd1) : 4'd0;

        case (state_q)
            S_MONITOR: begin
                if (event_any) begin
                    state_d = S_FAULT;
                    code_d  = event_code;
                    flash_d = 1'b1;
                    fcnt_d  = 8'd0;
                end else if (static_raw) begin
                    if (FILTER == 1) begin
                        state_d = S_FAULT;
                        code_d  = static_code;
                        flash_d = 1'b1;
                        fcnt_d  = 8'd0;
                    end else begin
                        state_d = S_PENDING;
                        filt_d  = 4'd1;
                    end
                end
            end
            S_PENDING: begin
                if (event_any) begin
                    state_d = S_FAULT;
                    code_d  = event_code;
                    flash_d = 1'b1;
                    fcnt_d  = 8'd0;
                    filt_d  = 4'd0;
                end else if (static_raw) begin
                    if (filt_q + 4'd1 >= FILT_N) begin
                        // Latch whatever static code is present on the final cycle
                        state_d = S_FAULT;
                        code_d  = static_code;
                        flash_d = 1'b1;
                        fcnt_d  = 8'd0;
                        filt_d  = 4'd0;
                    end else begin
                        filt_d = filt_q + 4'd1;
                    end
                end else begin
                    state_d = S_MONITOR;
                    filt_d  = 4'd0;
                end
            end
            S_FAULT: begin
                if (clr_fault && !static_raw) begin
                    state_d  = S_MONITOR;
                    code_d   = 3'd0;
                    flash_d  = 1'b0;
                    fcnt_d   = 8'd0;
                    filt_d   = 4'd0;
                    ycnt_a_d = 4'd0;
                    ycnt_b_d = 4'd0;
                end else if (fcnt_q == FH_M1) begin
                    flash_d = ~flash_q;
                    fcnt_d  = 8'd0;
                end else begin
                    fcnt_d = fcnt_q + 8'd1;
                end
            end
            default: begin
                state_d = S_MONITOR;
                code_d  = 3'd0;
                flash_d = 1'b0;
                fcnt_d  = 8'd0;
                filt_d  = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_MONITOR;
            code_q    <= 3'd0;
            flash_q   <= 1'b0;
            fcnt_q    <= 8'd0;
            filt_q    <= 4'd0;
            ycnt_a_q  <= 4'd0;
            ycnt_b_q  <= 4'd0;
            prev_ga_q <= 1'b0;
            prev_ya_q <= 1'b0;
            prev_gb_q <= 1'b0;
            prev_yb_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            flash_q   <= flash_d;
            fcnt_q    <= fcnt_d;
            filt_q    <= filt_d;
            ycnt_a_q  <= ycnt_a_d;
            ycnt_b_q  <= ycnt_b_d;
            prev_ga_q <= prev_ga_d;
            prev_ya_q <= prev_ya_d;
            prev_gb_q <= prev_gb_d;
            prev_yb_q <= prev_yb_d;
        end
    end

    assign fault      = (state_q == S_FAULT);
    assign fault_code = code_q;
    assign flash_on   = flash_q;
    assign ok         = ~fault;

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Directed, table-driven bench for traffic_conflict_monitor (default parameters).
module tb_traffic_conflict_monitor;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       Ga, Ya, Ra, Gb, Yb, Rb;
    logic       clr_fault;
    logic       fault;
    logic [2:0] fault_code;
    logic       flash_on;
    logic       ok;

    traffic_conflict_monitor #(.FILTER(2), .MIN_YELLOW(3), .FLASH_HALF(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .Ga         (Ga),
        .Ya         (Ya),
        .Ra         (Ra),
        .Gb         (Gb),
        .Yb         (Yb),
        .Rb         (Rb),
        .clr_fault  (clr_fault),
        .fault      (fault),
        .fault_code (fault_code),
        .flash_on   (flash_on),
        .ok         (ok)
    );

    always #5 clk = ~clk;

    // Lamp patterns {Ga,Ya,Ra,Gb,Yb,Rb}
    localparam logic [5:0] AG  = 6'b100_001;
    localparam logic [5:0] AY  = 6'b010_001;
    localparam logic [5:0] BG  = 6'b001_100;
    localparam logic [5:0] BY  = 6'b001_010;
    localparam logic [5:0] RR  = 6'b001_001;
    localparam logic [5:0] GG  = 6'b100_100;
    localparam logic [5:0] GBD = 6'b100_000;  // A green, B dark
    localparam logic [5:0] RBD = 6'b001_000;  // A red, B dark

    typedef struct {
        logic [5:0] lamps;
        logic       clr;
        logic       exp_fault;
        logic [2:0] exp_code;
        logic       exp_flash;
        string      name;
    } vec_t;

    vec_t vecs[$];
    int   n_pass = 0;
    int   n_chk  = 0;

    task automatic add(input logic [5:0] l, input logic c, input logic f,
                       input logic [2:0] cd, input logic fl, input string nm);
        vec_t v;
        v.lamps = l; v.clr = c; v.exp_fault = f; v.exp_code = cd; v.exp_flash = fl; v.name = nm;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [5:0] l, input logic c);
        {Ga, Ya, Ra, Gb, Yb, Rb} = l;
        clr_fault = c;
    endtask

    task automatic check(input string nm, input logic f, input logic [2:0] cd, input logic fl);
        logic [5:0] act, exp;
        act = {fault, fault_code, flash_on, ok};
        exp = {f, cd, fl, ~f};
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got fault=%b code=%0d flash=%b ok=%b, want fault=%b code=%0d flash=%b ok=%b",
                      nm, act[5], act[4:2], act[1], act[0], exp[5], exp[4:2], exp[1], exp[0]);
    endtask

    initial begin
        // Normal cycle, two rounds
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 6; i++) add(AG, 0, 0, 0, 0, "normal_ag");
            for (int i = 0; i < 3; i++) add(AY, 0, 0, 0, 0, "normal_ay");
            for (int i = 0; i < 5; i++) add(BG, 0, 0, 0, 0, "normal_bg");
            for (int i = 0; i < 3; i++) add(BY, 0, 0, 0, 0, "normal_by");
        end
        add(AG, 0, 0, 0, 0, "normal_ag");
        add(AG, 0, 0, 0, 0, "normal_ag");
        // One-cycle static glitch is filtered out
        add(GBD, 0, 0, 0, 0, "dark_1cyc_pending");
        add(AG,  0, 0, 0, 0, "dark_recover");
        // Conflict held two samples, then the flash pattern
        add(GG, 0, 0, 0, 0, "conflict_pending");
        add(GG, 0, 1, 1, 1, "conflict_latch");
        add(GG, 1, 1, 1, 1, "clr_ignored_static");
        add(GG, 0, 1, 1, 1, "flash_1c");
        add(GG, 0, 1, 1, 1, "flash_1d");
        add(GG, 0, 1, 1, 0, "flash_0a");
        add(GG, 0, 1, 1, 0, "flash_0b");
        add(GG, 0, 1, 1, 0, "flash_0c");
        add(GG, 0, 1, 1, 0, "flash_0d");
        add(GG, 0, 1, 1, 1, "flash_1e");
        add(AG, 1, 0, 0, 0, "clear_conflict");
        // Short yellow (2 cycles)
        for (int i = 0; i < 3; i++) add(AG, 0, 0, 0, 0, "sy_ag");
        add(AY, 0, 0, 0, 0, "sy_ay1");
        add(AY, 0, 0, 0, 0, "sy_ay2");
        add(RR, 0, 1, 4, 1, "short_yellow");
        add(RR, 1, 0, 0, 0, "clear_sy");
        // Full-length yellow is legal
        for (int i = 0; i < 4; i++) add(AG, 0, 0, 0, 0, "ly_ag");
        for (int i = 0; i < 3; i++) add(AY, 0, 0, 0, 0, "ly_ay");
        add(RR, 0, 0, 0, 0, "long_yellow_ok");
        // Green straight to red, with B dark on the same sample
        add(AG,  0, 0, 0, 0, "g2r_ag");
        add(RBD, 0, 1, 5, 1, "g2r_preempts_dark");
        add(RBD, 1, 1, 5, 1, "clr_ignored_dark");
        add(RR,  1, 0, 0, 0, "clear_g2r");
        add(AG,  0, 0, 0, 0, "pre_reset_ag");
        add(GG,  0, 0, 0, 0, "pre_reset_pend");
        add(GG,  0, 1, 1, 1, "pre_reset_fault");

        reset_n = 1'b0;
        drive(RR, 0);
        repeat (3) @(posedge clk);
        #1 check("reset_state", 0, 0, 0);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            drive(vecs[i].lamps, vecs[i].clr);
            @(posedge clk);
            #1 check(vecs[i].name, vecs[i].exp_fault, vecs[i].exp_code, vecs[i].exp_flash);
        end

        // Asynchronous reset between edges while in FAULT with Ga lit
        #2 reset_n = 1'b0;
        #1 check("async_reset_midfault", 0, 0, 0);
        #2 reset_n = 1'b1;
        drive(RR, 0);
        @(posedge clk);
        #1 check("post_reset_red_no_g2r", 0, 0, 0);
        drive(AG, 0);
        @(posedge clk);
        #1 check("post_reset_ag", 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
